// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the SBC6502 reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_POR       = 3'd0,
    ST_RUN       = 3'd1,
    ST_PRESS     = 3'd2,
    ST_WARM      = 3'd3,
    ST_COLD_HOLD = 3'd4,
    ST_COLD_TAIL = 3'd5,
    ST_WAIT_REL  = 3'd6
  } state_t;

  // Convert a time in microseconds into system clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned mhz);
    return us * mhz;
  endfunction

  // Largest of four cycle counts; sizes the shared timer.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer_key_debouncer.sv
// Two-flop synchroniser plus stability counter for an active-low pushbutton.
// level follows the synchronised input only after CYCLES consecutive samples
// of the new value; fall/rise are one-cycle strobes on each accepted change.
module key_debouncer #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int unsigned CW = $clog2(CYCLES) + 1;

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Synchronise the raw input; idles at the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Count consecutive differing samples; any sample matching level restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      fall <= 1'b0;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync;
        cnt   <= '0;
        fall  <= ~sync;
        rise  <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: power-on/lock-loss cold reset, short-press warm
// reset and long-press cold reset for the SBC6502 CPU board.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYSCLK_MHZ    = 50,
  parameter int unsigned DEBOUNCE_US   = 10000,
  parameter int unsigned LONG_PRESS_US = 2000000,
  parameter int unsigned PULSE_US      = 100,
  parameter int unsigned POR_US        = 1000
) (
  input  logic CLK,
  input  logic RESET_,
  input  logic KEY_,
  input  logic PLL_LOCKED,
  output logic COLD_RESET_,
  output logic WARM_RESET_,
  output logic RST_BUSY,
  output logic LONG_HELD
);

  localparam int unsigned DB_C    = us_to_cycles(DEBOUNCE_US, SYSCLK_MHZ);
  localparam int unsigned LONG_C  = us_to_cycles(LONG_PRESS_US, SYSCLK_MHZ);
  localparam int unsigned PULSE_C = us_to_cycles(PULSE_US, SYSCLK_MHZ);
  localparam int unsigned POR_C   = us_to_cycles(POR_US, SYSCLK_MHZ);
  localparam int unsigned MAX_C   = max4(DB_C, LONG_C, PULSE_C, POR_C);
  localparam int unsigned TW      = $clog2(MAX_C) + 1;

  logic          lock_m;
  logic          lock_s;
  logic          key_level;
  logic          key_press;
  logic          key_release;
  state_t        state;
  state_t        state_next;
  logic [TW-1:0] t;
  logic [TW-1:0] t_next;
  logic          cold_d;
  logic          warm_d;
  logic          long_d;

  // PLL lock synchroniser; resets to "not locked".
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= PLL_LOCKED;
      lock_s <= lock_m;
    end
  end

  key_debouncer #(
    .CYCLES(DB_C)
  ) u_key (
    .clk  (CLK),
    .rst_n(RESET_),
    .din  (KEY_),
    .level(key_level),
    .fall (key_press),
    .rise (key_release)
  );

  // State and shared timer registers.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state <= ST_POR;
      t     <= '0;
    end else begin
      state <= state_next;
      t     <= t_next;
    end
  end

  // Next state; timer restarts at zero on every transition and lock loss wins.
  always_comb begin
    state_next = state;
    t_next     = '0;
    if (!lock_s) begin
      state_next = ST_POR;
    end else begin
      case (state)
        ST_POR: begin
          if (t == TW'(POR_C - 1)) state_next = ST_RUN;
          else                     t_next     = t + TW'(1);
        end
        ST_RUN: begin
          if (key_press) state_next = ST_PRESS;
        end
        ST_PRESS: begin
          if (key_level)                 state_next = ST_WARM;
          else if (t == TW'(LONG_C - 1)) state_next = ST_COLD_HOLD;
          else                           t_next     = t + TW'(1);
        end
        ST_WARM: begin
          if (t == TW'(PULSE_C - 1)) state_next = key_level ? ST_RUN : ST_WAIT_REL;
          else                       t_next     = t + TW'(1);
        end
        ST_COLD_HOLD: begin
          if (key_release) state_next = ST_COLD_TAIL;
        end
        ST_COLD_TAIL: begin
          if (t == TW'(PULSE_C - 1)) state_next = ST_RUN;
          else                       t_next     = t + TW'(1);
        end
        ST_WAIT_REL: begin
          if (key_level) state_next = ST_RUN;
        end
        default: state_next = ST_POR;
      endcase
    end
  end

  // Output decode from the upcoming state so outputs change with the state.
  always_comb begin
    cold_d = 1'b1;
    warm_d = 1'b1;
    long_d = 1'b0;
    case (state_next)
      ST_POR, ST_COLD_TAIL: begin
        cold_d = 1'b0;
        warm_d = 1'b0;
      end
      ST_COLD_HOLD: begin
        cold_d = 1'b0;
        warm_d = 1'b0;
        long_d = 1'b1;
      end
      ST_WARM: warm_d = 1'b0;
      default: ;
    endcase
  end

  // Registered, glitch-free outputs.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      COLD_RESET_ <= 1'b0;
      WARM_RESET_ <= 1'b0;
      RST_BUSY    <= 1'b1;
      LONG_HELD   <= 1'b0;
    end else begin
      COLD_RESET_ <= cold_d;
      WARM_RESET_ <= warm_d;
      RST_BUSY    <= ~(cold_d & warm_d);
      LONG_HELD   <= long_d;
    end
  end

endmodule
